psum_acc_arb: RTL and testbench
===============================

# psum_acc_arb

Round-robin arbiter with an output register stage that shares the single psum accumulator write port among several MAC-array requesters. It sits between the MAC array lanes and the psum accumulator input. Bursts flagged by a per-requester `last` signal are kept atomic, so one lane's partial sums for a tile are never interleaved with another lane's beats. The block keeps a rotating priority pointer, a burst-lock state and a one-entry output holding register.

## Interface
- `N_REQ`, default 4: number of requesters, at least 2 and a power of 2.
- `ADDR_W`, default 32: psum address width.
- `DATA_W`, default 64: psum data width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_addr` input N_REQ*ADDR_W: requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_data` input N_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last` input N_REQ: beat is the final beat of requester i's burst.
- `req_vld` input N_REQ: requester i is offering a beat.
- `req_rdy` output N_REQ: beat from requester i is accepted this cycle.
- `psum_addr` output ADDR_W: registered address to the psum accumulator.
- `psum_data` output DATA_W: registered data to the psum accumulator.
- `psum_id` output log2(N_REQ): index of the requester that produced the registered beat.
- `psum_vld` output 1: registered beat is valid.
- `psum_rdy` input 1: the psum accumulator accepts the beat.

## Operation
- **Load enable:** `load_en = ~psum_vld | psum_rdy`. The output register can take a new beat when it is empty or draining this cycle.
- **Grant when unlocked:** the winner is the first i with `req_vld[i]=1`, scanning from `ptr` upward and wrapping modulo N_REQ.
- **Grant when locked:** the winner is `lock_id` only. All other requesters are ignored even if valid. If `req_vld[lock_id]=0`, nothing is granted.
- **Ready:** `req_rdy[i] = load_en & (i == winner) & req_vld[i]`. Ready is combinational and may depend on `req_vld`. A requester must not make `req_vld` depend on `req_rdy`.
- **On acceptance from requester w:**
  - The output register loads addr, data and id = w, and `psum_vld` becomes 1.
  - `ptr` becomes (w+1) mod N_REQ.
  - If `req_last[w]=0`, the arbiter locks onto w (`locked=1`, `lock_id=w`).
  - If `req_last[w]=1`, the arbiter unlocks.
- **Draining:** if `psum_vld & psum_rdy` and no new beat is accepted, `psum_vld` goes to 0.
- **No data transformation:** addr and data pass through unmodified. There is no arithmetic.
- **Stalled output:** while `psum_vld=1` and `psum_rdy=0`, `psum_addr`, `psum_data` and `psum_id` must not change. All `req_rdy` are 0.
- **Single-beat bursts:** a beat with `last=1` arriving while unlocked never locks. The pointer still advances.
- **Locked requester stalls:** if the locked requester drops `req_vld` mid-burst, the lock holds indefinitely. This is legal and keeps the burst atomic.
- **Reset mid-burst:** asserting `rst` clears the lock, the pointer and the output register immediately. Any beat held in the output register is discarded.

## Timing
- **Reset values:** `psum_vld=0`, `psum_addr=0`, `psum_data=0`, `psum_id=0`, `ptr=0`, `locked=0`, `lock_id=0`. `req_rdy` is all 0 while `rst` is high.
- **Latency:** a beat accepted at edge k is presented on `psum_*` from cycle k+1.
- **Throughput:** one beat per cycle when `psum_rdy` is held at 1. There are no bubbles between requesters and none between beats of a burst.
- **Simultaneous drain and load:** in the same cycle the register drains and reloads, and `psum_vld` stays 1.
- **Pointer wrap:** the pointer wraps from N_REQ-1 to 0. With all requesters valid and every beat `last=1`, grants rotate 0,1,2,…,N_REQ-1,0.
- **Registers:** all state updates on the rising edge of `clk` and is asynchronously cleared by `rst`.

## Test plan
- **Single requester:** after reset, requester 2 sends one beat (addr 0x10, data 0xAA, last=1) with `psum_rdy=1`. Required: `req_rdy[2]=1` in the same cycle; next cycle `psum_vld=1`, `psum_addr=0x10`, `psum_data=0xAA`, `psum_id=2`; `ptr=3`.
- **Round robin:** all 4 requesters continuously valid with `last=1` and `psum_rdy=1`. Required: `psum_id` sequence 0,1,2,3,0,1 on consecutive cycles, with no idle cycle.
- **Burst lock:** requester 1 sends a 3-beat burst (last on beat 3) while requesters 0, 2 and 3 are valid. Required: three consecutive `psum_id=1` beats, then `psum_id=2`. Requester 1 drops `req_vld` for 2 cycles mid-burst. Required: no other requester is granted during the gap.
- **Back-pressure:** `psum_rdy=0` for 5 cycles while a beat is held. Required: `psum_*` stable and all `req_rdy=0`. On the cycle `psum_rdy` returns to 1, a new beat is accepted and `psum_vld` stays 1.
- **Reset mid-burst:** requester 3 is locked after beat 1 of 4, then `rst` is pulsed. Required: `psum_vld=0` immediately. After release, with requesters 0 and 3 valid, requester 0 is granted first.
- **Parameter sweep:** `N_REQ=2` with alternating valid patterns. Required: grants strictly alternate 0,1,0,1 when both are valid, and no beat is lost or duplicated as checked by a scoreboard.

Source files
------------

// File: rtl/psum_acc_arb.sv
// psum_acc_arb: round-robin arbiter with atomic-burst lock that feeds the single
// psum accumulator write port through a one-entry output register.
module psum_acc_arb #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ-1:0]        req_vld,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [ADDR_W-1:0]       psum_addr,
  output logic [DATA_W-1:0]       psum_data,
  output logic [ID_W-1:0]         psum_id,
  output logic                    psum_vld,
  input  logic                    psum_rdy
);

  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_LOCK = 1'b1
  } lock_state_t;

  lock_state_t       state_q;
  lock_state_t       state_d;
  logic              locked;
  logic [ID_W-1:0]   lock_id_q;
  logic [ID_W-1:0]   ptr_q;

  logic [ID_W-1:0]   scan_idx;
  logic [ID_W-1:0]   win_id;
  logic              win_vld;
  logic              load_en;
  logic              accept;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic [ID_W-1:0]   id_p1;

  // Scan downward in offset so the requester closest to ptr is written last and wins.
  always_comb begin
    win_id   = '0;
    win_vld  = 1'b0;
    scan_idx = '0;
    if (locked) begin
      win_id  = lock_id_q;
      win_vld = req_vld[lock_id_q];
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        scan_idx = ptr_q + ID_W'(k);
        if (req_vld[scan_idx]) begin
          win_id  = scan_idx;
          win_vld = 1'b1;
        end
      end
    end
  end

  assign load_en = ~vld_p1 | psum_rdy;
  // Gated by rst so no requester sees a handshake while the block is held in reset.
  assign accept  = load_en & win_vld & ~rst;

  always_comb begin
    req_rdy         = '0;
    req_rdy[win_id] = accept;
  end

  // Lock FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OPEN;
      ptr_q     <= '0;
      lock_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q <= win_id + ID_W'(1);
        if (!req_last[win_id]) lock_id_q <= win_id;
      end
    end
  end

  // Lock FSM: next state
  always_comb begin
    state_d = state_q;
    if (accept) state_d = req_last[win_id] ? ST_OPEN : ST_LOCK;
  end

  // Lock FSM: outputs
  always_comb begin
    locked = (state_q == ST_LOCK);
  end

  // Stage p1: output holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      id_p1   <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      addr_p1 <= req_addr[int'(win_id)*ADDR_W +: ADDR_W];
      data_p1 <= req_data[int'(win_id)*DATA_W +: DATA_W];
      id_p1   <= win_id;
    end else if (psum_rdy) begin
      vld_p1  <= 1'b0;
    end
  end

  assign psum_vld  = vld_p1;
  assign psum_addr = addr_p1;
  assign psum_data = data_p1;
  assign psum_id   = id_p1;

endmodule

// File: tb/tb_psum_acc_arb.sv
// Bench for psum_acc_arb: directed scenarios plus random traffic on a 4-requester
// and a 2-requester instance, checked against a transaction-level reference model.
module tb_psum_acc_arb;
  localparam int A4 = 32;
  localparam int D4 = 64;
  localparam int A2 = 16;
  localparam int D2 = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4*A4-1:0] a4;
  logic [4*D4-1:0] d4;
  logic [3:0]      l4, v4, r4;
  logic [A4-1:0]   pa4;
  logic [D4-1:0]   pd4;
  logic [1:0]      pi4;
  logic            pv4, pr4;

  logic [2*A2-1:0] a2;
  logic [2*D2-1:0] d2;
  logic [1:0]      l2, v2, r2;
  logic [A2-1:0]   pa2;
  logic [D2-1:0]   pd2;
  logic            pi2, pv2, pr2;

  psum_acc_arb #(.N_REQ(4), .ADDR_W(A4), .DATA_W(D4)) u_dut4 (
    .clk(clk), .rst(rst), .req_addr(a4), .req_data(d4), .req_last(l4),
    .req_vld(v4), .req_rdy(r4), .psum_addr(pa4), .psum_data(pd4),
    .psum_id(pi4), .psum_vld(pv4), .psum_rdy(pr4)
  );

  psum_acc_arb #(.N_REQ(2), .ADDR_W(A2), .DATA_W(D2)) u_dut2 (
    .clk(clk), .rst(rst), .req_addr(a2), .req_data(d2), .req_last(l2),
    .req_vld(v2), .req_rdy(r2), .psum_addr(pa2), .psum_data(pd2),
    .psum_id(pi2), .psum_vld(pv2), .psum_rdy(pr2)
  );

  // Stimulus per instance: index 0 drives the 4-requester DUT, 1 the 2-requester DUT.
  bit          s_vld [2][4];
  bit          s_last[2][4];
  logic [31:0] s_addr[2][4];
  logic [63:0] s_data[2][4];
  bit          s_prdy[2];

  for (genvar i = 0; i < 4; i++) begin : g_pack4
    assign a4[i*A4 +: A4] = s_addr[0][i];
    assign d4[i*D4 +: D4] = s_data[0][i];
    assign l4[i]          = s_last[0][i];
    assign v4[i]          = s_vld[0][i];
  end
  for (genvar i = 0; i < 2; i++) begin : g_pack2
    assign a2[i*A2 +: A2] = s_addr[1][i][A2-1:0];
    assign d2[i*D2 +: D2] = s_data[1][i][D2-1:0];
    assign l2[i]          = s_last[1][i];
    assign v2[i]          = s_vld[1][i];
  end
  assign pr4 = s_prdy[0];
  assign pr2 = s_prdy[1];

  logic [3:0]  o_rdy [2];
  logic        o_vld [2];
  logic [63:0] o_addr[2];
  logic [63:0] o_data[2];
  logic [1:0]  o_id  [2];
  assign o_rdy[0]  = r4;
  assign o_rdy[1]  = {2'b00, r2};
  assign o_vld[0]  = pv4;
  assign o_vld[1]  = pv2;
  assign o_addr[0] = {32'b0, pa4};
  assign o_addr[1] = {48'b0, pa2};
  assign o_data[0] = pd4;
  assign o_data[1] = {48'b0, pd2};
  assign o_id[0]   = pi4;
  assign o_id[1]   = {1'b0, pi2};

  // Reference model: the registered beat plus arbitration state, in plain integers.
  int          nreq[2] = '{4, 2};
  bit          m_vld [2];
  logic [63:0] m_addr[2];
  logic [63:0] m_data[2];
  int          m_id  [2];
  int          m_ptr [2];
  bit          m_lock[2];
  int          m_lid [2];

  logic [63:0] sb_data[$];
  int          sb_id[$];

  logic [3:0]  last_rdy[2];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int winner(int d);
    if (m_lock[d]) return s_vld[d][m_lid[d]] ? m_lid[d] : -1;
    for (int k = 0; k < nreq[d]; k++) begin
      int i;
      i = (m_ptr[d] + k) % nreq[d];
      if (s_vld[d][i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d]  = 1'b0;
      m_addr[d] = '0;
      m_data[d] = '0;
      m_id[d]   = 0;
      m_ptr[d]  = 0;
      m_lock[d] = 1'b0;
      m_lid[d]  = 0;
    end
    sb_data.delete();
    sb_id.delete();
  endtask

  // One clock: check handshakes mid-cycle, advance the model at the edge, check outputs after.
  task automatic cycle();
    int         w[2];
    bit         acc[2];
    logic [3:0] er;
    #1;
    for (int d = 0; d < 2; d++) begin
      w[d]   = winner(d);
      acc[d] = (!m_vld[d] || s_prdy[d]) && (w[d] >= 0);
      er = '0;
      if (acc[d]) er[w[d]] = 1'b1;
      last_rdy[d] = o_rdy[d];
      check($sformatf("req_rdy_d%0d", d), 64'(o_rdy[d]), 64'(er));
    end
    if (o_vld[1] && s_prdy[1]) begin
      check("sb_nonempty", 64'(sb_data.size() != 0), 64'(1));
      if (sb_data.size() != 0) begin
        check("sb_data", o_data[1], sb_data.pop_front());
        check("sb_id", 64'(o_id[1]), 64'(sb_id.pop_front()));
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (acc[d]) begin
        m_vld[d]  = 1'b1;
        m_addr[d] = 64'(s_addr[d][w[d]]);
        m_data[d] = s_data[d][w[d]];
        m_id[d]   = w[d];
        m_ptr[d]  = (w[d] + 1) % nreq[d];
        if (s_last[d][w[d]]) m_lock[d] = 1'b0;
        else begin
          m_lock[d] = 1'b1;
          m_lid[d]  = w[d];
        end
        if (d == 1) begin
          sb_data.push_back(m_data[1]);
          sb_id.push_back(w[1]);
        end
      end else if (s_prdy[d]) begin
        m_vld[d] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("psum_vld_d%0d", d), 64'(o_vld[d]), 64'(m_vld[d]));
      check($sformatf("psum_addr_d%0d", d), o_addr[d], m_addr[d]);
      check($sformatf("psum_data_d%0d", d), o_data[d], m_data[d]);
      check($sformatf("psum_id_d%0d", d), 64'(o_id[d]), 64'(m_id[d]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_vld_d%0d", d), 64'(o_vld[d]), 64'(0));
      check($sformatf("rst_rdy_d%0d", d), 64'(o_rdy[d]), 64'(0));
      check($sformatf("rst_addr_d%0d", d), o_addr[d], 64'(0));
      check($sformatf("rst_data_d%0d", d), o_data[d], 64'(0));
      check($sformatf("rst_id_d%0d", d), 64'(o_id[d]), 64'(0));
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_vld();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) s_vld[d][i] = 1'b0;
  endtask

  task automatic set_pattern4(input bit last);
    for (int i = 0; i < 4; i++) begin
      s_addr[0][i] = 32'h100 + 32'(i);
      s_data[0][i] = 64'hD0 + 64'(i);
      s_last[0][i] = last;
      s_vld[0][i]  = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      s_prdy[d] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        s_vld[d][i]  = (i < nreq[d]);
        s_last[d][i] = 1'b1;
        s_addr[d][i] = '0;
        s_data[d][i] = '0;
      end
    end
    #2;
    do_reset();
    clear_vld();

    // Single beat from requester 2
    s_vld[0][2]  = 1'b1;
    s_addr[0][2] = 32'h10;
    s_data[0][2] = 64'hAA;
    s_last[0][2] = 1'b1;
    cycle();
    check("single_rdy", 64'(last_rdy[0]), 64'h4);
    check("single_vld", 64'(pv4), 64'(1));
    check("single_addr", 64'(pa4), 64'h10);
    check("single_data", pd4, 64'hAA);
    check("single_id", 64'(pi4), 64'(2));
    set_pattern4(1'b1);
    cycle();
    check("ptr_after_single", 64'(pi4), 64'(3));

    // Round robin on both instances, every beat last
    do_reset();
    set_pattern4(1'b1);
    for (int i = 0; i < 2; i++) begin
      s_vld[1][i]  = 1'b1;
      s_last[1][i] = 1'b1;
      s_addr[1][i] = 32'h20 + 32'(i);
      s_data[1][i] = 64'h30 + 64'(i);
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_vld", 64'(pv4), 64'(1));
      check("rr_id", 64'(pi4), 64'(k % 4));
      check("alt_id", 64'(pi2), 64'(k % 2));
    end

    // Burst lock on requester 1 with a two-cycle gap
    do_reset();
    clear_vld();
    set_pattern4(1'b1);
    for (int i = 0; i < 4; i++) s_vld[0][i] = (i == 1);
    s_last[0][1] = 1'b0;
    cycle();
    check("burst_b1_id", 64'(pi4), 64'(1));
    s_vld[0][0] = 1'b1;
    s_vld[0][2] = 1'b1;
    s_vld[0][3] = 1'b1;
    cycle();
    check("burst_b2_id", 64'(pi4), 64'(1));
    s_vld[0][1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("burst_gap_rdy", 64'(last_rdy[0]), 64'(0));
    end
    check("burst_gap_vld", 64'(pv4), 64'(0));
    s_vld[0][1]  = 1'b1;
    s_last[0][1] = 1'b1;
    cycle();
    check("burst_b3_rdy", 64'(last_rdy[0]), 64'h2);
    check("burst_b3_id", 64'(pi4), 64'(1));
    s_vld[0][1] = 1'b0;
    cycle();
    check("burst_next_id", 64'(pi4), 64'(2));

    // Back-pressure while the requester-2 beat is held
    s_prdy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_rdy", 64'(last_rdy[0]), 64'(0));
      check("bp_vld", 64'(pv4), 64'(1));
      check("bp_addr", 64'(pa4), 64'h102);
      check("bp_data", pd4, 64'hD2);
      check("bp_id", 64'(pi4), 64'(2));
    end
    s_prdy[0] = 1'b1;
    cycle();
    check("bp_resume_rdy", 64'(last_rdy[0]), 64'h8);
    check("bp_resume_vld", 64'(pv4), 64'(1));
    check("bp_resume_id", 64'(pi4), 64'(3));

    // Reset while requester 3 is locked mid-burst
    do_reset();
    clear_vld();
    s_vld[0][3]  = 1'b1;
    s_last[0][3] = 1'b0;
    cycle();
    check("rstb_lock_id", 64'(pi4), 64'(3));
    s_vld[0][0] = 1'b1;
    do_reset();
    cycle();
    check("rstb_post_rdy", 64'(last_rdy[0]), 64'h1);
    check("rstb_post_id", 64'(pi4), 64'(0));

    // Random traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < nreq[d]; i++) begin
          s_vld[d][i]  = ($urandom_range(0, 2) != 0);
          s_last[d][i] = ($urandom_range(0, 2) == 0);
          s_addr[d][i] = (d == 0) ? 32'($urandom) : 32'($urandom_range(0, 16'hFFFF));
          s_data[d][i] = (d == 0) ? {32'($urandom), 32'($urandom)} : {48'b0, 16'($urandom)};
        end
        s_prdy[d] = ($urandom_range(0, 3) != 0);
      end
      if (c == 1500) do_reset();
      cycle();
    end

    clear_vld();
    s_prdy[0] = 1'b1;
    s_prdy[1] = 1'b1;
    repeat (3) cycle();
    check("sb_left", 64'(sb_data.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
